// File: rtl/input_cond_pkg.sv
// Purpose: shared state encoding and default timing constants for the input conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package input_cond_pkg;

  // Default debounce window and long-press threshold, in core clock cycles.
  localparam int DB_CYCLES_DEF = 4;
  localparam int LP_CYCLES_DEF = 16;

  // Per-button debounce FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

endpackage

// File: rtl/input_conditioner_debounce_fsm.sv
// Purpose: 2-flop synchroniser plus press/release debounce FSM for one raw button.
// Latency: level changes DB_CYCLES+3 edges after the first edge sampling a stable new raw value.
// Backpressure: none; the raw input is sampled every cycle.
module debounce_fsm
  import input_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic press_evt,
  output logic pressed
);

  localparam int              CW       = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          btn_s;
  db_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  assign btn_s = sync_q[1];

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], raw};
  end

  // State and debounce counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; the counter is cleared on every state entry so it never wraps.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nx = PRESS_WAIT;
          cnt_nx   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_nx = RELEASE_WAIT;
          cnt_nx   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs decoded from state; press_evt is the combinational PRESS_WAIT->PRESSED strobe.
  always_comb begin
    level     = (state == PRESSED) || (state == RELEASE_WAIT);
    pressed   = (state == PRESSED);
    press_evt = (state == PRESS_WAIT) && (state_nx == PRESSED);
  end

  // Registered press pulse: high for the one cycle following the press transition.
  always_ff @(posedge clk) begin
    if (!rst_n) press_pulse <= 1'b0;
    else        press_pulse <= press_evt;
  end

endmodule

// File: rtl/input_conditioner.sv
// Purpose: synchronise switches, debounce two buttons, derive mux-select toggle, latch pulse, long press.
// Latency: data 2 edges; button levels/pulses/toggle DB_CYCLES+3 edges; long press LP_CYCLES after PRESSED.
// Backpressure: none. Optional long-press detector enabled by macro INPUT_CONDITIONER_LONG_PRESS_EN.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int LP_CYCLES = LP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       btn0_raw,
  input  logic       btn1_raw,
  output logic [7:0] data,
  output logic       btn0,
  output logic       btn1,
  output logic       btn1_pulse,
  output logic       btn0_long
);

  logic [7:0] sw_s1, sw_s2;
  logic       b0_level, b0_pulse, b0_evt, b0_pressed;
  logic       b1_level, b1_pulse, b1_evt, b1_pressed;
  logic       btn0_q;

  // Two-stage synchroniser for the slide switches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  assign data = sw_s2;

  debounce_fsm #(.DB_CYCLES(DB_CYCLES)) u_btn0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (btn0_raw),
    .level      (b0_level),
    .press_pulse(b0_pulse),
    .press_evt  (b0_evt),
    .pressed    (b0_pressed)
  );

  debounce_fsm #(.DB_CYCLES(DB_CYCLES)) u_btn1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw        (btn1_raw),
    .level      (b1_level),
    .press_pulse(b1_pulse),
    .press_evt  (b1_evt),
    .pressed    (b1_pressed)
  );

  // Mux select flips on the same edge that btn0 enters PRESSED.
  always_ff @(posedge clk) begin
    if (!rst_n) btn0_q <= 1'b0;
    else        btn0_q <= btn0_q ^ b0_evt;
  end

  assign btn0       = btn0_q;
  assign btn1       = b1_level;
  assign btn1_pulse = b1_pulse;

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  localparam int            LW      = $clog2(LP_CYCLES + 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LP_CYCLES - 1);
  localparam logic [LW-1:0] LP_FULL = LW'(LP_CYCLES);

  logic [LW-1:0] lp_cnt;
  logic          long_q;
  logic          unused_sigs;

  // Long-press counter: counts in PRESSED, holds through RELEASE_WAIT bounces so a
  // brief dropout does not restart the press, clears once the press is fully released.
  // Saturating at LP_CYCLES guarantees a single pulse per press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lp_cnt <= '0;
      long_q <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (!b0_level) begin
        lp_cnt <= '0;
      end else if (b0_pressed && (lp_cnt != LP_FULL)) begin
        lp_cnt <= lp_cnt + 1'b1;
        long_q <= (lp_cnt == LP_LAST);
      end
    end
  end

  assign btn0_long   = long_q;
  assign unused_sigs = ^{b0_pulse, b1_evt, b1_pressed};
`else
  logic            unused_sigs;
  localparam int   unused_lp_cycles = LP_CYCLES;

  assign btn0_long   = 1'b0;
  assign unused_sigs = ^{b0_level, b0_pulse, b0_pressed, b1_evt, b1_pressed};
`endif

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn0_raw, btn1_raw;
  logic [7:0] data;
  logic       btn0, btn1, btn1_pulse, btn0_long;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  input_conditioner #(.DB_CYCLES(4), .LP_CYCLES(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn0_raw  (btn0_raw),
    .btn1_raw  (btn1_raw),
    .data      (data),
    .btn0      (btn0),
    .btn1      (btn1),
    .btn1_pulse(btn1_pulse),
    .btn0_long (btn0_long)
  );

`ifdef INPUT_CONDITIONER_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  typedef struct {
    logic       rst_n;
    logic [7:0] sw;
    logic       b0;
    logic       b1;
    logic [7:0] e_data;
    logic       e_b0;
    logic       e_b1;
    logic       e_p;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [7:0] s, logic b0, logic b1,
                              logic [7:0] ed, logic eb0, logic eb1, logic ep, string nm);
    vec_t v;
    v.rst_n = r;  v.sw = s;  v.b0 = b0;  v.b1 = b1;
    v.e_data = ed; v.e_b0 = eb0; v.e_b1 = eb1; v.e_p = ep; v.nm = nm;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [7:0] s, input logic b0, input logic b1);
    rst_n = r; sw = s; btn0_raw = b0; btn1_raw = b1;
  endtask

  task automatic expect_out(input string nm, input logic [7:0] ed, input logic eb0,
                            input logic eb1, input logic ep, input logic el);
    logic [11:0] got, exp;
    got = {data, btn0, btn1, btn1_pulse, btn0_long};
    exp = {ed, eb0, eb1, ep, el};
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got data=%h btn0=%b btn1=%b pulse=%b long=%b, want data=%h btn0=%b btn1=%b pulse=%b long=%b",
               nm, $time, got[11:4], got[3], got[2], got[1], got[0],
               exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One edge with given inputs, then compare.
  task automatic cyc(input string nm, input logic r, input logic [7:0] s, input logic b0,
                     input logic b1, input logic [7:0] ed, input logic eb0, input logic eb1,
                     input logic ep, input logic el);
    drive(r, s, b0, b1);
    step();
    expect_out(nm, ed, eb0, eb1, ep, el);
  endtask

  initial begin
    drive(1'b0, 8'hFF, 1'b1, 1'b1);

    // Reset with everything high, release, switch sync latency, then a clean btn1 press.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 8'hFF, 1, 1, 8'h00, 0, 0, 0, "reset"));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 8'h00, 0, 0, 0, "rel_e1"));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 8'hFF, 0, 0, 0, "rel_e2"));
    tbl.push_back(mk(1, 8'hFF, 0, 0, 8'hFF, 0, 0, 0, "rel_e3"));
    for (int e = 1; e <= 9; e++)
      tbl.push_back(mk(1, 8'hFF, 0, 1, 8'hFF, 0, (e >= 7), (e == 7), $sformatf("b1press_e%0d", e)));
    tbl.push_back(mk(1, 8'h5A, 0, 1, 8'hFF, 0, 1, 0, "sw_e1"));
    tbl.push_back(mk(1, 8'h5A, 0, 1, 8'h5A, 0, 1, 0, "sw_e2"));
    tbl.push_back(mk(1, 8'h5A, 0, 1, 8'h5A, 0, 1, 0, "sw_e3"));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].sw, tbl[i].b0, tbl[i].b1);
      step();
      expect_out(tbl[i].nm, tbl[i].e_data, tbl[i].e_b0, tbl[i].e_b1, tbl[i].e_p, 1'b0);
    end

    // btn1 dropout of 2 cycles while PRESSED: level held, no second pulse.
    for (int e = 1; e <= 10; e++)
      cyc($sformatf("b1glitch_e%0d", e), 1, 8'h5A, 0, (e > 2), 8'h5A, 0, 1, 0, 0);

    // btn1 release: level falls exactly at edge 7.
    for (int e = 1; e <= 8; e++)
      cyc($sformatf("b1rel_e%0d", e), 1, 8'h5A, 0, 0, 8'h5A, 0, (e < 7), 0, 0);

    // btn0 bounce with 2-cycle widths: no toggle.
    begin
      logic [11:0] pat;
      pat = 12'b1100_1100_0000;
      for (int e = 1; e <= 12; e++)
        cyc($sformatf("b0bounce_e%0d", e), 1, 8'h5A, pat[12-e], 0, 8'h5A, 0, 0, 0, 0);
    end

    // First clean btn0 press toggles to 1 at edge 7, holds through release.
    for (int e = 1; e <= 9; e++)
      cyc($sformatf("b0press1_e%0d", e), 1, 8'h5A, 1, 0, 8'h5A, (e >= 7), 0, 0, 0);
    for (int e = 1; e <= 8; e++)
      cyc($sformatf("b0rel1_e%0d", e), 1, 8'h5A, 0, 0, 8'h5A, 1, 0, 0, 0);

    // Second clean btn0 press toggles back to 0.
    for (int e = 1; e <= 9; e++)
      cyc($sformatf("b0press2_e%0d", e), 1, 8'h5A, 1, 0, 8'h5A, (e < 7), 0, 0, 0);
    for (int e = 1; e <= 8; e++)
      cyc($sformatf("b0rel2_e%0d", e), 1, 8'h5A, 0, 0, 8'h5A, 0, 0, 0, 0);

    // Simultaneous presses behave independently.
    for (int e = 1; e <= 10; e++)
      cyc($sformatf("both_e%0d", e), 1, 8'h5A, 1, 1, 8'h5A, (e >= 7), (e >= 7), (e == 7), 0);
    for (int e = 1; e <= 8; e++)
      cyc($sformatf("bothrel_e%0d", e), 1, 8'h5A, 0, 0, 8'h5A, 1, (e < 7), 0, 0);

    // Reset during btn1 PRESS_WAIT: aborted, then re-debounced from IDLE.
    for (int e = 1; e <= 4; e++)
      cyc($sformatf("pw_e%0d", e), 1, 8'h5A, 0, 1, 8'h5A, 1, 0, 0, 0);
    for (int e = 1; e <= 2; e++)
      cyc($sformatf("midrst_e%0d", e), 0, 8'h5A, 0, 1, 8'h00, 0, 0, 0, 0);
    for (int e = 1; e <= 10; e++)
      cyc($sformatf("postrst_e%0d", e), 1, 8'h5A, 0, 1, (e >= 2) ? 8'h5A : 8'h00,
          0, (e >= 7), (e == 7), 0);
    for (int e = 1; e <= 8; e++)
      cyc($sformatf("postrst_rel_e%0d", e), 1, 8'h5A, 0, 0, 8'h5A, 0, (e < 7), 0, 0);

    // Long btn0 hold: single long pulse 16 cycles after PRESSED entry (edge 7 -> edge 23).
    for (int e = 1; e <= 40; e++)
      cyc($sformatf("long_e%0d", e), 1, 8'h5A, 1, 0, 8'h5A, (e >= 7), 0, 0, LP_EN && (e == 23));
    for (int e = 1; e <= 8; e++)
      cyc($sformatf("longrel_e%0d", e), 1, 8'h5A, 0, 0, 8'h5A, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 4, stable-input clock cycles required to accept a button level change (1_000_000 = 10 ms at 100 MHz in the board build).
REQ-002 Parameter LP_CYCLES, default 16, cycles btn0 must remain in PRESSED before a long-press pulse is emitted.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 sw  in  8  raw slide switches, asynchronous.
REQ-006 btn0_raw  in  1  raw mux-select button, asynchronous, bouncy.
REQ-007 btn1_raw  in  1  raw latch-enable button, asynchronous, bouncy.
REQ-008 data  out  8  synchronised switch byte, feeds the latch/mux stage data input.
REQ-009 btn0  out  1  mux select; toggles on each accepted btn0 press.
REQ-010 btn1  out  1  debounced btn1 level; drives the latch enable.
REQ-011 btn1_pulse  out  1  one-cycle pulse on each accepted btn1 press.
REQ-012 btn0_long  out  1  one-cycle long-press pulse; see Configuration.

Function
REQ-013 sw, btn0_raw and btn1_raw shall each pass through a 2-flop synchroniser; data shall equal the second synchroniser stage of sw.
REQ-014 Each button shall have an FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a counter sized $clog2(DB_CYCLES)+1 bits.
REQ-015 IDLE: when the synchronised input is 1, go to PRESS_WAIT with count=0.
REQ-016 PRESS_WAIT: if the input is 0, return to IDLE; if count==DB_CYCLES-1, go to PRESSED; otherwise increment count.
REQ-017 PRESSED: when the input is 0, go to RELEASE_WAIT with count=0.
REQ-018 RELEASE_WAIT: if the input is 1, return to PRESSED; if count==DB_CYCLES-1, go to IDLE; otherwise increment count.
REQ-019 The debounced level shall be 1 in PRESSED and RELEASE_WAIT, and 0 otherwise.
REQ-020 Latency: with a stable input, the debounced level shall change exactly DB_CYCLES+3 rising edges after the first edge that samples the new raw value.
REQ-021 The press event shall be the PRESS_WAIT->PRESSED transition; btn1_pulse shall be high for exactly the one cycle after that transition; btn0 shall toggle on that same edge.
REQ-022 A bounce shorter than DB_CYCLES cycles shall produce no level change, no pulse and no toggle.
REQ-023 Simultaneous presses on both buttons shall be processed independently, with no interaction.
REQ-024 The counter shall never wrap; it is cleared on every state entry.

Reset
REQ-025 While rst_n=0 at a clock edge: all FSMs shall go to IDLE, counters shall clear, and synchronisers shall clear to 0.
REQ-026 The reset value of every output shall be 0: data, btn0, btn1, btn1_pulse and btn0_long.
REQ-027 A reset asserted mid-debounce or mid-press shall abort the operation with no pulse; a button still held at release shall be re-debounced from IDLE.

Configuration
REQ-028 Macro INPUT_CONDITIONER_LONG_PRESS_EN.
REQ-029 When the macro is defined: a counter shall run while the btn0 FSM is in PRESSED; btn0_long shall pulse for one cycle when that count reaches LP_CYCLES; it shall fire at most once per press; the counter shall clear on leaving PRESSED and shall hold in RELEASE_WAIT.
REQ-030 When the macro is undefined: btn0_long shall be tied to 0 and no long-press counter shall exist.

Structure
REQ-031 Package input_cond_pkg shall hold the FSM state typedef (IDLE/PRESS_WAIT/PRESSED/RELEASE_WAIT) and the default DB_CYCLES/LP_CYCLES constants.
REQ-032 Sub-module debounce_fsm (synchroniser, FSM and counter; outputs level and press pulse) shall be instantiated once per button; the toggle and long-press logic shall live in the top level.

Verification (DB_CYCLES=4, LP_CYCLES=16)
REQ-033 Hold rst_n=0 with sw=8'hFF and both buttons 1 -> all outputs 0; release reset -> data=8'hFF exactly 2 edges later.
REQ-034 Raise btn1_raw and hold it -> btn1 rises at edge 7; btn1_pulse is high for exactly 1 cycle; btn0 is unchanged.
REQ-035 Toggle btn0_raw 1/0/1/0 with 2-cycle widths, then leave it at 0 -> btn0 stays 0 and there is no pulse; a next clean press -> btn0=1; a second clean press -> btn0=0.
REQ-036 Hold btn1 in PRESSED, drop btn1_raw for 2 cycles, then restore it -> btn1 stays 1 and there is no second btn1_pulse.
REQ-037 Assert rst_n=0 during PRESS_WAIT with btn1_raw still high -> no pulse; after release, btn1 rises 7 edges later.
REQ-038 With the macro defined, hold btn0 for 40 cycles -> exactly one btn0_long pulse, 16 cycles after PRESSED entry; with the macro undefined -> btn0_long stays 0.
